// File: rtl/accum_pkg.sv
// accum_pkg: shared opcode/state types and default width for the accumulator stage
package accum_pkg;
  localparam int ACCUM_DW_DEFAULT = 8;
  typedef enum logic [1:0] {CLR = 2'b00, LOAD = 2'b01, ADD = 2'b10, SUB = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;
endpackage

// File: rtl/accum_alu.sv
// accum_alu: combinational clr/load/add/sub with flags; ACCUM_SAT_EN clamps signed overflow
module accum_alu
  import accum_pkg::*;
#(
  parameter int DW = ACCUM_DW_DEFAULT
) (
  input  logic [DW-1:0] acc,
  input  logic [DW-1:0] d,
  input  op_e           op,
  output logic [DW-1:0] r,
  output logic          carry,
  output logic          ovf,
  output logic          zero
);
  logic [DW-1:0] b;
  logic [DW-1:0] wrap;
  logic [DW:0]   sum;
  logic          arith;
  always_comb begin
    arith = op == ADD || op == SUB;
    b     = op == SUB ? ~d : d;
    sum   = {1'b0, acc} + {1'b0, b} + {{DW{1'b0}}, op == SUB};
    carry = arith && sum[DW];
    ovf   = arith && acc[DW-1] == b[DW-1] && sum[DW-1] != acc[DW-1];
    wrap  = arith ? sum[DW-1:0] : op == LOAD ? d : '0;
`ifdef ACCUM_SAT_EN
    r     = !ovf ? wrap : acc[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
    r     = wrap;
`endif
    zero  = r == '0;
  end
endmodule

// File: rtl/accum_seq.sv
// accum_seq: valid/ready sequenced accumulator (IDLE->EXEC->HOLD), out_data is the accumulator
module accum_seq
  import accum_pkg::*;
#(
  parameter int DW = ACCUM_DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_carry,
  output logic          out_ovf,
  output logic          out_zero
);
  state_e        state;
  op_e           op_q;
  logic [DW-1:0] d_q;
  logic [DW-1:0] r;
  logic          carry;
  logic          ovf;
  logic          zero;
  assign in_ready = state == IDLE;
  accum_alu #(.DW(DW)) u_alu (
    .acc  (out_data),
    .d    (d_q),
    .op   (op_q),
    .r    (r),
    .carry(carry),
    .ovf  (ovf),
    .zero (zero)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= CLR;
      d_q       <= '0;
      out_data  <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_valid <= 1'b0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          op_q  <= op_e'(in_op);
          d_q   <= in_data;
          state <= EXEC;
        end
        EXEC: begin
          out_data  <= r;
          out_carry <= carry;
          out_ovf   <= ovf;
          out_zero  <= zero;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_accum_seq.sv
// tb_accum_seq: table vectors, backpressure/reset sequences and random commands vs arithmetic model
module tb_accum_seq;
  localparam logic [1:0] OP_CLR = 2'b00, OP_LD = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11;
  logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic       in_ready, out_valid, out_carry, out_ovf, out_zero;
  logic [1:0] in_op = 0;
  logic [7:0] in_data = 0, out_data, m_acc = 0;
  int         compared = 0, mismatched = 0;
  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] q;
    logic       c, o, z;
  } vec_t;
  vec_t tbl[10];
  accum_seq #(.DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask
  function automatic logic [10:0] model(input logic [1:0] op, input logic [7:0] d);
    int a = m_acc, b = d, sa = $signed(m_acc), sb = $signed(d), st = 0;
    logic c = 0, o = 0;
    logic [7:0] res = 0;
    if (op == OP_LD) res = d;
    if (op == OP_ADD) begin
      c = a + b > 255;
      st = sa + sb;
      res = 8'(a + b);
    end
    if (op == OP_SUB) begin
      c = a >= b;
      st = sa - sb;
      res = 8'(a - b);
    end
    o = st > 127 || st < -128;
`ifdef ACCUM_SAT_EN
    if (o) res = st > 0 ? 8'h7F : 8'h80;
`endif
    m_acc = res;
    return {res, c, o, res == 8'h00};
  endfunction
  task automatic issue(input logic [1:0] op, input logic [7:0] d, output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1;
    in_op = op;
    in_data = d;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_op = 2'($urandom);
    in_data = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic consume(input int dly);
    repeat (dly) @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
  endtask
  task automatic run(input string nm, input logic [1:0] op, input logic [7:0] d, input logic [10:0] exp, input int dly);
    int lat;
    issue(op, d, lat);
    check({nm, " latency"}, lat, 2);
    check({nm, " result"}, {out_data, out_carry, out_ovf, out_zero}, exp);
    consume(dly);
  endtask
  initial begin
    logic [10:0] e;
    int lat;
    tbl[0] = '{OP_LD, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{OP_ADD, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{OP_LD, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0};
`ifdef ACCUM_SAT_EN
    tbl[3] = '{OP_ADD, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
`else
    tbl[3] = '{OP_ADD, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
`endif
    tbl[4] = '{OP_LD, 8'h03, 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{OP_SUB, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{OP_LD, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0};
`ifdef ACCUM_SAT_EN
    tbl[7] = '{OP_SUB, 8'h01, 8'h80, 1'b1, 1'b1, 1'b0};
`else
    tbl[7] = '{OP_SUB, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
`endif
    tbl[8] = '{OP_LD, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{OP_ADD, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    check("reset outputs", {out_valid, out_data, out_carry, out_ovf, out_zero}, 0);
    rst_n = 1;
    @(negedge clk);
    check("in_ready after reset", in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      e = model(tbl[i].op, tbl[i].d);
      run($sformatf("vec%0d", i), tbl[i].op, tbl[i].d, {tbl[i].q, tbl[i].c, tbl[i].o, tbl[i].z}, 0);
    end
    run("clr", OP_CLR, 8'h5A, 11'b00000000_001, 0);
    e = model(OP_CLR, 0);
    e = model(OP_LD, 8'h40);
    run("bp load", OP_LD, 8'h40, e, 0);
    e = model(OP_ADD, 8'h11);
    issue(OP_ADD, 8'h11, lat);
    in_valid = 1;
    in_op = OP_LD;
    in_data = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold%0d", i), {out_valid, in_ready, out_data, out_carry, out_ovf, out_zero}, {2'b10, e});
    end
    in_valid = 0;
    consume(0);
    check("bp release", {in_ready, out_valid}, 2'b10);
    e = model(OP_ADD, 8'h00);
    run("bp not consumed", OP_ADD, 8'h00, e, 0);
    @(negedge clk);
    in_valid = 1;
    in_op = OP_ADD;
    in_data = 8'h05;
    @(posedge clk);
    #1;
    in_valid = 0;
    rst_n = 0;
    #2;
    check("mid reset", {out_valid, in_ready, out_data, out_carry, out_ovf, out_zero}, 12'b01_00000000_000);
    @(negedge clk);
    rst_n = 1;
    m_acc = 0;
    repeat (3) @(negedge clk);
    check("no pulse after reset", out_valid, 0);
    e = model(OP_ADD, 8'h02);
    run("add after reset", OP_ADD, 8'h02, e, 0);
    for (int i = 0; i < 200; i++) begin
      logic [1:0] op;
      logic [7:0] d;
      op = $urandom_range(9) == 0 ? OP_CLR : $urandom_range(5) == 0 ? OP_LD : $urandom_range(1) ? OP_ADD : OP_SUB;
      d = 8'($urandom);
      e = model(op, d);
      run($sformatf("rand%0d", i), op, d, e, $urandom_range(3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
